// File: rtl/vending_ctrl.sv
// vending_ctrl
// Vending-machine controller. Debounces active-low coin and confirm buttons.
// Accumulates credit, prices the selected products from a packed price table,
// and runs the CREDIT -> SELECT -> VEND/FAIL -> CREDIT sequence. The sequence
// includes change/refund computation, a selection timeout and a dwell time.
//
// Ports:
//   iCLK_50MHZ   in   system clock
//   iRST         in   synchronous active-high reset
//   coin_n       in   [N_COIN]   coin buttons, active-low, asynchronous
//   confirm_n    in   confirm/advance button, active-low, asynchronous
//   sel          in   [N_PROD]   product select switches (level)
//   state_o      out  [2]        0=CREDIT 1=SELECT 2=VEND 3=FAIL
//   led          out  [4]        one-hot of state_o
//   credit       out  [CREDIT_W] accumulated credit
//   total        out  [CREDIT_W] price sum of selected products (combinational)
//   change       out  [CREDIT_W] change (VEND) or refund (FAIL), else 0
//   vend_pulse   out  one-cycle pulse on entry to VEND
//   coin_reject  out  one-cycle pulse when a coin press is refused
module vending_ctrl #(
  parameter int                          N_PROD         = 4,
  parameter int                          PRICE_W        = 4,
  parameter logic [N_PROD*PRICE_W-1:0]   PRICES         = {4'd2, 4'd2, 4'd2, 4'd2},
  parameter int                          N_COIN         = 3,
  parameter logic [N_COIN*4-1:0]         COIN_VALS      = {4'd5, 4'd2, 4'd1},
  parameter int                          CREDIT_W       = 8,
  parameter int                          DEB_CYCLES     = 750000,
  parameter int                          HOLD_CYCLES    = 100000000,
  parameter int                          TIMEOUT_CYCLES = 1500000000
) (
  input  logic                iCLK_50MHZ,
  input  logic                iRST,
  input  logic [N_COIN-1:0]   coin_n,
  input  logic                confirm_n,
  input  logic [N_PROD-1:0]   sel,
  output logic [1:0]          state_o,
  output logic [3:0]          led,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] total,
  output logic [CREDIT_W-1:0] change,
  output logic                vend_pulse,
  output logic                coin_reject
);

  localparam logic [1:0] ST_CREDIT = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_FAIL   = 2'd3;

  // Coin buttons occupy indices 0..N_COIN-1; confirm is the top button.
  localparam int N_BTN   = N_COIN + 1;
  localparam int DCW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMR_LIM = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = (TMR_LIM > 1) ? $clog2(TMR_LIM) : 1;

  localparam logic [DCW-1:0] DEB_MAX  = DCW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_MAX = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Debounce: 2-flop synchronizer, stability counter, registered press pulse
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] r_sync1, r_sync2, r_deb, r_deb_d, r_press;
  logic [DCW-1:0]   r_deb_cnt [N_BTN];

  assign w_raw = {confirm_n, coin_n};

  always_ff @(posedge iCLK_50MHZ) begin
    // NOTE: every register in a clocked block uses <= so all of them sample
    // pre-edge values; blocking = here would make the order of lines matter.
    if (iRST) begin
      // Buttons idle high, so the whole chain resets to the released level
      // to avoid a spurious press right after reset.
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      r_deb_d <= '1;
      r_press <= '0;
      for (int b = 0; b < N_BTN; b++) r_deb_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Press fires one cycle after the debounced level falls.
      r_press <= r_deb_d & ~r_deb;
      for (int b = 0; b < N_BTN; b++) begin
        if (r_sync2[b] != r_deb[b]) begin
          if (r_deb_cnt[b] == DEB_MAX) begin
            r_deb[b]     <= r_sync2[b];
            r_deb_cnt[b] <= '0;
          end else begin
            r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
          end
        end else begin
          r_deb_cnt[b] <= '0;
        end
      end
    end
  end

  logic [N_COIN-1:0] w_coin_press;
  logic              w_confirm;
  assign w_coin_press = r_press[N_COIN-1:0];
  assign w_confirm    = r_press[N_COIN];

  // ---------------------------------------------------------------------------
  // Price total
  // ---------------------------------------------------------------------------
  logic [CREDIT_W-1:0] w_total;

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block free of
    // inferred latches regardless of which branches are taken.
    w_total = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) w_total = w_total + CREDIT_W'(PRICES[i*PRICE_W +: PRICE_W]);
    end
  end

  // ---------------------------------------------------------------------------
  // Coin arbitration: lowest pressed index wins in CREDIT, all else refused
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit, r_change;
  logic [TW-1:0]       r_tmr;
  logic                r_vend_pulse, r_coin_reject;

  logic                w_found, w_rej_other;
  logic [3:0]          w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_accept, w_reject;

  always_comb begin
    w_found     = 1'b0;
    w_rej_other = 1'b0;
    w_coin_val  = '0;
    for (int j = 0; j < N_COIN; j++) begin
      if (w_coin_press[j]) begin
        if (r_state != ST_CREDIT || w_found) begin
          w_rej_other = 1'b1;
        end else begin
          w_found    = 1'b1;
          w_coin_val = COIN_VALS[j*4 +: 4];
        end
      end
    end
  end

  // One extra bit catches credit overflow.
  assign w_sum    = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
  assign w_accept = w_found & ~w_sum[CREDIT_W];
  assign w_reject = w_rej_other | (w_found & w_sum[CREDIT_W]);

  // ---------------------------------------------------------------------------
  // Main sequencer; r_tmr is shared as SELECT timeout and VEND/FAIL dwell
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK_50MHZ) begin
    if (iRST) begin
      r_state       <= ST_CREDIT;
      r_credit      <= '0;
      r_change      <= '0;
      r_tmr         <= '0;
      r_vend_pulse  <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_vend_pulse  <= 1'b0;
      r_coin_reject <= w_reject;
      case (r_state)
        ST_CREDIT: begin
          if (w_accept) r_credit <= w_sum[CREDIT_W-1:0];
          if (w_confirm) begin
            r_state <= ST_SELECT;
            r_tmr   <= '0;
          end
        end
        ST_SELECT: begin
          // Confirm is tested first so it wins over a coincident timeout.
          if (w_confirm) begin
            r_tmr <= '0;
            if (w_total != '0 && r_credit >= w_total) begin
              r_state      <= ST_VEND;
              r_change     <= r_credit - w_total;
              r_vend_pulse <= 1'b1;
            end else begin
              r_state  <= ST_FAIL;
              r_change <= r_credit;
            end
          end else if (r_tmr == TMO_MAX) begin
            r_tmr    <= '0;
            r_state  <= ST_FAIL;
            r_change <= r_credit;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin  // ST_VEND, ST_FAIL
          if (w_confirm || r_tmr == HOLD_MAX) begin
            r_state  <= ST_CREDIT;
            r_credit <= '0;
            r_change <= '0;
            r_tmr    <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
      endcase
    end
  end

  assign state_o     = r_state;
  assign led         = 4'b0001 << r_state;
  assign credit      = r_credit;
  assign total       = w_total;
  assign change      = r_change;
  assign vend_pulse  = r_vend_pulse;
  assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl
// Directed bench for vending_ctrl. Uses short debounce/hold/timeout parameters.
// CREDIT_W is 4 so that the overflow case can be reached quickly.
// PRICE_W is 2 and every price is 2, so sel=0111 gives a total of 6.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] coin_n = 3'b111;
  logic       confirm_n = 1'b1;
  logic [3:0] sel = 4'b0000;

  logic [1:0] state_o;
  logic [3:0] led;
  logic [3:0] credit, total, change;
  logic       vend_pulse, coin_reject;

  int n_checks = 0;
  int n_pass   = 0;
  int rej_cnt  = 0;
  int vend_cnt = 0;

  vending_ctrl #(
    .N_PROD(4), .PRICE_W(2), .PRICES({2'd2, 2'd2, 2'd2, 2'd2}),
    .N_COIN(3), .COIN_VALS({4'd5, 4'd2, 4'd1}), .CREDIT_W(4),
    .DEB_CYCLES(4), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(50)
  ) u_dut (
    .iCLK_50MHZ (clk),
    .iRST       (rst),
    .coin_n     (coin_n),
    .confirm_n  (confirm_n),
    .sel        (sel),
    .state_o    (state_o),
    .led        (led),
    .credit     (credit),
    .total      (total),
    .change     (change),
    .vend_pulse (vend_pulse),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coin_reject === 1'b1) rej_cnt++;
    if (vend_pulse === 1'b1) vend_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // mask bits [2:0] = coins, bit 3 = confirm; held long enough to debounce.
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    coin_n    = ~mask[2:0];
    confirm_n = ~mask[3];
    repeat (10) @(negedge clk);
    coin_n    = 3'b111;
    confirm_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Press confirm and return at the first negedge where state_o == target.
  task automatic confirm_to(input logic [1:0] target, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    confirm_n = 1'b0;
    while (state_o !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    confirm_n = 1'b1;
    check(tag, state_o, target);
  endtask

  task automatic wait_state(input logic [1:0] target, input string tag);
    int n;
    n = 0;
    while (state_o !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, state_o, target);
  endtask

  initial begin
    int r0, v0, n;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_credit", credit, 0);
    check("rst_change", change, 0);
    check("rst_led", led, 4'b0001);
    check("rst_vend", vend_pulse, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_total", total, 0);

    // Coin accumulation 1, 3, 8
    r0 = rej_cnt;
    press(4'b0001); check("acc_c0", credit, 1);
    press(4'b0010); check("acc_c1", credit, 3);
    press(4'b0100); check("acc_c2", credit, 8);
    check("acc_noreject", rej_cnt - r0, 0);
    check("acc_state", state_o, 0);
    check("acc_led", led, 4'b0001);

    // Successful vend: total 6, change 2, dwell 8 cycles
    sel = 4'b0111;
    #1 check("vend_total", total, 6);
    v0 = vend_cnt;
    confirm_to(2'd1, "vend_to_select");
    check("select_led", led, 4'b0010);
    repeat (10) @(negedge clk);
    confirm_to(2'd2, "vend_to_vend");
    check("vend_pulse_first", vend_pulse, 1);
    check("vend_change", change, 2);
    check("vend_led", led, 4'b0100);
    n = 1;
    @(negedge clk);
    while (state_o === 2'd2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("vend_dwell", n, 8);
    check("vend_back_state", state_o, 0);
    check("vend_back_credit", credit, 0);
    check("vend_back_change", change, 0);
    check("vend_pulse_count", vend_cnt - v0, 1);
    repeat (10) @(negedge clk);

    // Insufficient credit: credit 3, total 4 -> FAIL refund 3
    press(4'b0001); press(4'b0010);
    check("insuf_credit", credit, 3);
    sel = 4'b0011;
    #1 check("insuf_total", total, 4);
    confirm_to(2'd1, "insuf_to_select");
    repeat (10) @(negedge clk);
    confirm_to(2'd3, "insuf_to_fail");
    check("insuf_change", change, 3);
    check("insuf_led", led, 4'b1000);
    wait_state(2'd0, "insuf_back");
    repeat (10) @(negedge clk);

    // Empty selection -> FAIL even with credit
    press(4'b0001); press(4'b0010);
    sel = 4'b0000;
    confirm_to(2'd1, "empty_to_select");
    repeat (10) @(negedge clk);
    confirm_to(2'd3, "empty_to_fail");
    check("empty_change", change, 3);
    wait_state(2'd0, "empty_back");
    repeat (10) @(negedge clk);

    // Timeout: 50 cycles in SELECT, refund 5
    press(4'b0100);
    check("tmo_credit", credit, 5);
    confirm_to(2'd1, "tmo_to_select");
    n = 1;
    @(negedge clk);
    while (state_o === 2'd1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tmo_dwell", n, 50);
    check("tmo_state", state_o, 3);
    check("tmo_change", change, 5);
    wait_state(2'd0, "tmo_back");
    repeat (10) @(negedge clk);

    // Overflow and simultaneous coins (CREDIT_W = 4)
    press(4'b0100); press(4'b0100); press(4'b0010);
    check("ovf_credit12", credit, 12);
    r0 = rej_cnt;
    press(4'b0100);
    check("ovf_hold", credit, 12);
    check("ovf_reject", rej_cnt - r0, 1);
    r0 = rej_cnt;
    press(4'b0011);
    check("simul_credit", credit, 13);
    check("simul_reject", rej_cnt - r0, 1);

    // Confirm press lands on the timeout cycle -> VEND, change 13-6
    sel = 4'b0111;
    confirm_to(2'd1, "race_to_select");
    repeat (42) @(negedge clk);
    confirm_n = 1'b0;
    repeat (7) @(negedge clk);
    check("race_pre", state_o, 1);
    @(negedge clk);
    check("race_state", state_o, 2);
    check("race_change", change, 7);
    confirm_n = 1'b1;
    wait_state(2'd0, "race_back");
    repeat (10) @(negedge clk);

    // 3-cycle glitch on coin 0 is ignored
    r0 = rej_cnt;
    @(negedge clk);
    coin_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    coin_n[0] = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_credit", credit, 0);
    check("glitch_reject", rej_cnt - r0, 0);

    // Reset during VEND
    press(4'b0100); press(4'b0010);
    check("rstv_credit", credit, 7);
    confirm_to(2'd1, "rstv_to_select");
    repeat (10) @(negedge clk);
    confirm_to(2'd2, "rstv_to_vend");
    rst = 1'b1;
    @(negedge clk);
    check("rstv_state", state_o, 0);
    check("rstv_credit0", credit, 0);
    check("rstv_change", change, 0);
    check("rstv_vend", vend_pulse, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised vending-machine controller: debounces active-low coin and confirm pushbuttons, accumulates credit, prices a multi-product selection from a per-product price table, and sequences credit → select → vend/refund with change computation and selection timeout. Sits between the board pushbuttons/switches and the LCD text generator and LEDs. The state code, credit, total and change outputs feed the display character lookup.

## Interface
Parameters:
- N_PROD, 4: number of product select switches.
- PRICE_W, 4: width of one price entry.
- PRICES, {4'd2,4'd2,4'd2,4'd2}: packed N_PROD×PRICE_W table; entry i occupies bits [i*PRICE_W +: PRICE_W].
- N_COIN, 3: number of coin buttons.
- COIN_VALS, {4'd5,4'd2,4'd1}: packed N_COIN×4 coin values; entry j occupies bits [j*4 +: 4].
- CREDIT_W, 8: width of credit, total and change. Constraint: N_PROD×(2^PRICE_W−1) < 2^CREDIT_W.
- DEB_CYCLES, 750000: cycles a raw level must differ from the debounced level before it is accepted. Must be ≥1.
- HOLD_CYCLES, 100000000: dwell time in VEND/FAIL.
- TIMEOUT_CYCLES, 1500000000: maximum time in SELECT without confirm.

Ports (clock and reset first):
- iCLK_50MHZ  in  1  system clock. One clock; reset is synchronous and active-high.
- iRST  in  1  synchronous active-high reset.
- coin_n  in  N_COIN  coin buttons, active-low, asynchronous.
- confirm_n  in  1  advance/confirm button, active-low, asynchronous.
- sel  in  N_PROD  product select switches, level, sampled directly.
- state_o  out  2  0=CREDIT, 1=SELECT, 2=VEND, 3=FAIL.
- led  out  4  one-hot of state_o (led[state_o]=1).
- credit  out  CREDIT_W  accumulated credit.
- total  out  CREDIT_W  price sum of selected products.
- change  out  CREDIT_W  change (VEND) or refund (FAIL); otherwise 0.
- vend_pulse  out  1  one-cycle pulse on entry to VEND.
- coin_reject  out  1  one-cycle pulse when a coin is refused.

## Operation
- Debounce, per button:
  - Raw input passes through a 2-flop synchronizer.
  - A counter runs while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEB_CYCLES−1, the debounced level takes the synchronized level.
  - A press pulse (1 cycle, registered) fires on the debounced 1→0 transition. Release generates no pulse.
  - Debounced levels reset to 1.
- total: combinational sum of PRICES[i] for every set sel[i]. It is zero-extended to CREDIT_W and tracks sel in all states.
- CREDIT:
  - A coin-j press adds COIN_VALS[j] to credit.
  - If credit + value > 2^CREDIT_W−1, credit is unchanged and coin_reject pulses.
  - Simultaneous coin presses in one cycle: only the lowest index is accepted; the others pulse coin_reject.
  - A confirm press goes to SELECT.
- SELECT:
  - Coin presses are refused with coin_reject; credit is frozen.
  - The timeout counter starts at 0 on entry.
  - On a confirm press:
    - If total≠0 and credit≥total, go to VEND and latch change=credit−total.
    - Otherwise go to FAIL and latch change=credit.
  - If the counter reaches TIMEOUT_CYCLES−1 with no confirm, go to FAIL and latch change=credit.
  - Confirm and timeout in the same cycle: confirm wins.
- VEND / FAIL:
  - Coins are refused.
  - The hold counter starts at 0 on entry.
  - At HOLD_CYCLES−1, or on a confirm press (whichever comes first), go to CREDIT and clear credit and change to 0.
- Reset (any state, mid-debounce included): state=CREDIT; credit, change, counters and pulses are 0; debounced levels are 1.

## Timing
- Button to press pulse: 2 (sync) + DEB_CYCLES + 1 cycles after the raw edge is held stable.
- Press pulse to register update: next edge. credit, state_o and change are updated 1 cycle after the pulse.
- vend_pulse is high in the first cycle state_o==2.
- coin_reject is high in the cycle after the refused press pulse.
- led and total are combinational from state_o and sel; no added latency.
- All outputs are registered except total and led.
- Glitches shorter than DEB_CYCLES produce no pulse.

## Test plan
- Coin accumulation (DEB_CYCLES=4, defaults otherwise): press coins 0,1,2 once each → credit reaches 1, 3, then 8; no coin_reject; state_o=0, led=0001.
- Successful vend: credit=8, sel=4'b0111 (total=6), confirm, confirm → vend_pulse once, state_o=2, change=2. After HOLD_CYCLES=8 → state_o=0, credit=0, change=0.
- Insufficient credit and empty selection:
  - credit=3, sel=4'b0011 (total=4), confirm twice → state_o=3, change=3.
  - Repeat with sel=0 → state_o=3.
- Overflow and simultaneous coins:
  - CREDIT_W=4, credit=12, press coin 2 (value 5) → credit stays 12, coin_reject pulses.
  - Press coins 0 and 1 in the same cycle → credit=13, one coin_reject.
- Timeout and confirm-beats-timeout:
  - TIMEOUT_CYCLES=50, enter SELECT with credit=5, no confirm → FAIL at cycle 50, change=5.
  - Confirm pulse aligned with the timeout cycle and credit≥total → VEND.
- Debounce and reset:
  - 3-cycle low glitch on coin_n[0] (DEB_CYCLES=4) → no credit change.
  - Assert iRST during VEND → next cycle state_o=0, credit=0, change=0, vend_pulse=0.
